// File: rtl/spi_master_slave.sv
// Byte-wide SPI master and SPI slave sharing one clock, reset and SPI mode.
// The master drives SCLK/MOSI; the slave answers on a tri-stated MISO under CS_n.
module spi_master_slave #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_M_TX_Byte,
  input  logic       i_M_TX_DV,
  output logic       o_M_TX_Ready,
  output logic       o_M_RX_DV,
  output logic [7:0] o_M_RX_Byte,
  output logic       o_M_SPI_Clk,
  input  logic       i_M_SPI_MISO,
  output logic       o_M_SPI_MOSI,
  input  logic       i_S_TX_DV,
  input  logic [7:0] i_S_TX_Byte,
  output logic       o_S_RX_DV,
  output logic [7:0] o_S_RX_Byte,
  input  logic       i_S_SPI_Clk,
  input  logic       i_S_SPI_MOSI,
  output logic       o_S_SPI_MISO,
  input  logic       i_S_SPI_CS_n
);

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam int   CW   = $clog2(CLKS_PER_HALF_BIT);
  localparam logic [CW-1:0] HALF_MAX = CW'(CLKS_PER_HALF_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_clk_cnt;
  logic [4:0]    r_edges;
  logic [7:0]    r_m_tx, r_m_rx_sh, r_m_rx_byte;
  logic          r_m_sclk, r_m_mosi;
  logic          w_start, w_tick, w_lead, w_last;
  logic          w_m_shift, w_m_sample;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: w_next = i_M_TX_DV ? S_XFER : S_IDLE;
      S_XFER:         if (w_last) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_M_TX_Ready = (r_state != S_XFER);
    o_M_RX_DV    = (r_state == S_DONE);
  end

  // r_edges counts down from 16; even values are leading edges
  assign w_start    = i_M_TX_DV && o_M_TX_Ready;
  assign w_tick     = (r_state == S_XFER) && (r_clk_cnt == HALF_MAX);
  assign w_lead     = w_tick && !r_edges[0];
  assign w_last     = w_tick && (r_edges == 5'd1);
  assign w_m_shift  = CPHA ? w_lead : (w_tick && r_edges[0]);
  assign w_m_sample = CPHA ? (w_tick && r_edges[0]) : w_lead;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_clk_cnt   <= '0;
      r_edges     <= '0;
      r_m_tx      <= '0;
      r_m_rx_sh   <= '0;
      r_m_rx_byte <= '0;
      r_m_sclk    <= CPOL;
      r_m_mosi    <= 1'b0;
    end else if (w_start) begin
      r_m_tx    <= CPHA ? i_M_TX_Byte : {i_M_TX_Byte[6:0], 1'b0};
      r_edges   <= 5'd16;
      r_clk_cnt <= '0;
      r_m_sclk  <= CPOL;
      if (!CPHA) r_m_mosi <= i_M_TX_Byte[7];
    end else if (r_state == S_XFER) begin
      r_clk_cnt <= w_tick ? '0 : r_clk_cnt + 1'b1;
      if (w_tick) begin
        r_m_sclk <= ~r_m_sclk;
        r_edges  <= r_edges - 5'd1;
      end
      if (w_m_shift) begin
        r_m_mosi <= r_m_tx[7];
        r_m_tx   <= {r_m_tx[6:0], 1'b0};
      end
      if (w_m_sample) r_m_rx_sh <= {r_m_rx_sh[6:0], i_M_SPI_MISO};
      if (w_last)
        r_m_rx_byte <= CPHA ? {r_m_rx_sh[6:0], i_M_SPI_MISO} : r_m_rx_sh;
    end
  end

  assign o_M_RX_Byte  = r_m_rx_byte;
  assign o_M_SPI_Clk  = r_m_sclk;
  assign o_M_SPI_MOSI = r_m_mosi;

  logic       r_s_sclk, r_armed, r_s_rx_dv, r_s_miso;
  logic [2:0] r_s_cnt;
  logic [7:0] r_s_rx_sh, r_s_rx_byte, r_hold, r_s_tx;
  logic       w_s_lead, w_s_trail, w_s_active, w_s_sample, w_s_shift;

  assign w_s_lead   = (i_S_SPI_Clk != CPOL) && (r_s_sclk == CPOL);
  assign w_s_trail  = (i_S_SPI_Clk == CPOL) && (r_s_sclk != CPOL);
  assign w_s_active = r_armed && !i_S_SPI_CS_n;
  assign w_s_sample = w_s_active && (CPHA ? w_s_trail : w_s_lead);
  assign w_s_shift  = w_s_active && (CPHA ? w_s_lead : w_s_trail);

  // After reset the slave stays silent until it has seen CS_n high
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_s_sclk    <= CPOL;
      r_armed     <= 1'b0;
      r_s_cnt     <= '0;
      r_s_rx_sh   <= '0;
      r_s_rx_byte <= '0;
      r_s_rx_dv   <= 1'b0;
      r_hold      <= '0;
      r_s_tx      <= '0;
      r_s_miso    <= 1'b0;
    end else begin
      r_s_sclk  <= i_S_SPI_Clk;
      r_s_rx_dv <= 1'b0;
      if (i_S_TX_DV) r_hold <= i_S_TX_Byte;
      if (i_S_SPI_CS_n) begin
        r_armed  <= 1'b1;
        r_s_cnt  <= '0;
        r_s_tx   <= {r_hold[6:0], 1'b0};
        r_s_miso <= r_hold[7];
      end else if (r_armed) begin
        if (w_s_sample) begin
          r_s_rx_sh <= {r_s_rx_sh[6:0], i_S_SPI_MOSI};
          r_s_cnt   <= r_s_cnt + 3'd1;
          if (r_s_cnt == 3'd7) begin
            r_s_rx_byte <= {r_s_rx_sh[6:0], i_S_SPI_MOSI};
            r_s_rx_dv   <= 1'b1;
          end
        end
        // a shift edge with the counter at zero starts a new byte
        if (w_s_shift) begin
          if (r_s_cnt == 3'd0) begin
            r_s_tx   <= {r_hold[6:0], 1'b0};
            r_s_miso <= r_hold[7];
          end else begin
            r_s_tx   <= {r_s_tx[6:0], 1'b0};
            r_s_miso <= r_s_tx[7];
          end
        end
      end
    end
  end

  assign o_S_RX_DV    = r_s_rx_dv;
  assign o_S_RX_Byte  = r_s_rx_byte;
  assign o_S_SPI_MISO = w_s_active ? r_s_miso : 1'bz;

endmodule

// File: tb/tb_spi_master_slave.sv
// Loopback bench: four instances (SPI modes 0..3) driven with the same
// byte stream, checked against a transaction-level model of the block.
module tb_spi_master_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_l, m_dv, cs_n;
  logic [7:0] m_byte;
  logic       m_ready [4];
  logic       m_rx_dv [4];
  logic       m_sclk  [4];
  logic       m_mosi  [4];
  logic       s_rx_dv [4];
  logic       miso_seen [4];
  logic [7:0] m_rx_byte [4];
  logic [7:0] s_rx_byte [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    wire w_miso;
    pullup (w_miso);
    spi_master_slave #(
      .SPI_MODE(g),
      .CLKS_PER_HALF_BIT(2)
    ) u_dut (
      .i_Clk       (clk),
      .i_Rst_L     (rst_l),
      .i_M_TX_Byte (m_byte),
      .i_M_TX_DV   (m_dv),
      .o_M_TX_Ready(m_ready[g]),
      .o_M_RX_DV   (m_rx_dv[g]),
      .o_M_RX_Byte (m_rx_byte[g]),
      .o_M_SPI_Clk (m_sclk[g]),
      .i_M_SPI_MISO(w_miso),
      .o_M_SPI_MOSI(m_mosi[g]),
      .i_S_TX_DV   (s_rx_dv[g]),
      .i_S_TX_Byte (s_rx_byte[g]),
      .o_S_RX_DV   (s_rx_dv[g]),
      .o_S_RX_Byte (s_rx_byte[g]),
      .i_S_SPI_Clk (m_sclk[g]),
      .i_S_SPI_MOSI(m_mosi[g]),
      .o_S_SPI_MISO(w_miso),
      .i_S_SPI_CS_n(cs_n)
    );
    assign miso_seen[g] = w_miso;
  end

  // transaction model: expected slave bytes, expected master bytes
  logic [7:0] exp_s [0:31];
  logic [7:0] exp_m [0:31];
  bit         exp_m_vld [0:31];
  int         s_wr, m_wr;
  logic [7:0] hold;

  int   srd [4], mrd [4], lat [4], edges [4];
  bit   busy [4];
  logic prev_sclk [4];
  bit   mon_en;
  int   n_chk, n_fail;

  task automatic check(input bit ok, input string nm,
                       input int act, input int exp_v);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  function automatic logic cpol(input int i);
    return (i >= 2);
  endfunction

  task automatic mon();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!mon_en) begin
          busy[i]      = 1'b0;
          mrd[i]       = m_wr;
          prev_sclk[i] = m_sclk[i];
        end else begin
          if (busy[i]) begin
            lat[i]++;
            if (m_sclk[i] != prev_sclk[i]) edges[i]++;
            if (m_rx_dv[i]) begin
              check(lat[i] >= 33 && lat[i] <= 35,
                    $sformatf("mode%0d latency", i), lat[i], 34);
              check(m_ready[i] == 1'b1,
                    $sformatf("mode%0d ready at rx_dv", i), m_ready[i], 1);
              check(edges[i] == 16,
                    $sformatf("mode%0d sclk edges", i), edges[i], 16);
              if (exp_m_vld[mrd[i]])
                check(m_rx_byte[i] == exp_m[mrd[i]],
                      $sformatf("mode%0d m_rx_byte", i),
                      m_rx_byte[i], exp_m[mrd[i]]);
              mrd[i]++;
              busy[i] = 1'b0;
            end else begin
              check(m_ready[i] == 1'b0,
                    $sformatf("mode%0d ready while busy", i), m_ready[i], 0);
              if (lat[i] > 40) begin
                check(1'b0, $sformatf("mode%0d m_rx_dv timeout", i),
                      lat[i], 34);
                mrd[i]++;
                busy[i] = 1'b0;
              end
            end
          end else begin
            check(m_sclk[i] == cpol(i),
                  $sformatf("mode%0d sclk idle", i), m_sclk[i], cpol(i));
            check(m_rx_dv[i] == 1'b0,
                  $sformatf("mode%0d spurious m_rx_dv", i), m_rx_dv[i], 0);
          end
          prev_sclk[i] = m_sclk[i];
          if (m_dv) begin
            if (!busy[i]) begin
              check(m_ready[i] == 1'b1,
                    $sformatf("mode%0d ready for dv", i), m_ready[i], 1);
              busy[i]  = 1'b1;
              lat[i]   = 0;
              edges[i] = 0;
            end else begin
              check(m_ready[i] == 1'b0,
                    $sformatf("mode%0d dv while busy", i), m_ready[i], 0);
            end
          end
          if (s_rx_dv[i]) begin
            if (srd[i] < s_wr)
              check(s_rx_byte[i] == exp_s[srd[i]],
                    $sformatf("mode%0d s_rx_byte", i),
                    s_rx_byte[i], exp_s[srd[i]]);
            else
              check(1'b0, $sformatf("mode%0d unexpected s_rx_dv", i),
                    s_rx_byte[i], 0);
            srd[i]++;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit part);
    exp_m[m_wr]     = hold;
    exp_m_vld[m_wr] = !part;
    m_wr++;
    if (!part) begin
      exp_s[s_wr] = b;
      s_wr++;
      hold = b;
    end
    tick();
    m_byte = b;
    m_dv   = 1'b1;
    tick();
    m_dv   = 1'b0;
  endtask

  task automatic wait_ready();
    bit done = 1'b0;
    int k    = 0;
    while (!done && k < 80) begin
      @(negedge clk);
      done = m_ready[0] && m_ready[1] && m_ready[2] && m_ready[3];
      k++;
    end
    check(done, "ready timeout", k, 34);
    repeat (2) tick();
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 4; i++) begin
      check(m_ready[i] == 1'b1, $sformatf("%s%0d ready", tag, i),
            m_ready[i], 1);
      check(m_rx_dv[i] == 1'b0, $sformatf("%s%0d m_rx_dv", tag, i),
            m_rx_dv[i], 0);
      check(m_rx_byte[i] == 8'h00, $sformatf("%s%0d m_rx_byte", tag, i),
            m_rx_byte[i], 0);
      check(m_sclk[i] == cpol(i), $sformatf("%s%0d sclk", tag, i),
            m_sclk[i], cpol(i));
      check(m_mosi[i] == 1'b0, $sformatf("%s%0d mosi", tag, i),
            m_mosi[i], 0);
      check(s_rx_dv[i] == 1'b0, $sformatf("%s%0d s_rx_dv", tag, i),
            s_rx_dv[i], 0);
      check(s_rx_byte[i] == 8'h00, $sformatf("%s%0d s_rx_byte", tag, i),
            s_rx_byte[i], 0);
      check(miso_seen[i] == 1'b1, $sformatf("%s%0d miso not z", tag, i),
            miso_seen[i], 1);
    end
  endtask

  task automatic chk_lit(input logic [7:0] es, input logic [7:0] em,
                         input string tag);
    for (int i = 0; i < 4; i++) begin
      check(s_rx_byte[i] == es, $sformatf("%s%0d slave byte", tag, i),
            s_rx_byte[i], es);
      check(m_rx_byte[i] == em, $sformatf("%s%0d master byte", tag, i),
            m_rx_byte[i], em);
    end
  endtask

  logic [7:0] seq [6];

  initial begin
    rst_l  = 1'b0;
    cs_n   = 1'b1;
    m_dv   = 1'b0;
    m_byte = 8'h00;
    hold   = 8'h00;
    mon_en = 1'b0;
    n_chk  = 0;
    n_fail = 0;
    s_wr   = 0;
    m_wr   = 0;
    for (int i = 0; i < 4; i++) srd[i] = 0;
    fork
      mon();
    join_none
    repeat (3) tick();
    chk_reset("rst_init_mode");
    rst_l = 1'b1;
    tick();
    mon_en = 1'b1;

    cs_n = 1'b0; tick();
    send(8'hC1, 1'b0);
    wait_ready();
    chk_lit(8'hC1, 8'h00, "first_mode");
    cs_n = 1'b1; tick();

    seq = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h55, 8'hAA};
    cs_n = 1'b0; tick();
    for (int j = 0; j < 6; j++) begin
      send(seq[j], 1'b0);
      wait_ready();
    end
    chk_lit(8'hAA, 8'h55, "multi_mode");
    cs_n = 1'b1; tick();

    cs_n = 1'b0; tick();
    send(8'hA5, 1'b0);
    wait_ready();
    chk_lit(8'hA5, 8'hAA, "a5_mode");
    cs_n = 1'b1; tick();

    cs_n = 1'b0; tick();
    send(8'h0F, 1'b1);
    repeat (16) tick();
    cs_n = 1'b1;
    wait_ready();
    cs_n = 1'b0; tick();
    send(8'h3C, 1'b0);
    wait_ready();
    chk_lit(8'h3C, 8'hA5, "partial_mode");
    cs_n = 1'b1; tick();

    cs_n = 1'b0; tick();
    send(8'h96, 1'b0);
    repeat (8) tick();
    m_byte = 8'h77;
    m_dv   = 1'b1;
    tick();
    m_dv   = 1'b0;
    wait_ready();
    chk_lit(8'h96, 8'h3C, "busy_dv_mode");
    cs_n = 1'b1; tick();

    cs_n = 1'b0; tick();
    send(8'hE7, 1'b1);
    repeat (8) tick();
    mon_en = 1'b0;
    rst_l  = 1'b0;
    tick();
    chk_reset("rst_mid_mode");
    rst_l = 1'b1;
    hold  = 8'h00;
    tick();
    cs_n = 1'b1;
    tick();
    mon_en = 1'b1;

    cs_n = 1'b0; tick();
    send(8'h5A, 1'b0);
    wait_ready();
    chk_lit(8'h5A, 8'h00, "post_rst_mode");
    cs_n = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < 4; i++)
      check(srd[i] == 11, $sformatf("mode%0d slave byte count", i),
            srd[i], 11);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_slave.md
# spi_master_slave

Single-clock SPI block holding two independent engines: a byte-wide SPI master (generates SCLK/MOSI, samples MISO) and a byte-wide SPI slave (receives on MOSI, answers on MISO under CS_n). Both engines share one system clock and one reset and use the same SPI mode. The block sits between register/control logic and an SPI bus, and supports board-level loopback (master wired to slave).

## Interface
- SPI_MODE, 0: 0..3; CPOL = mode 2 or 3, CPHA = mode 1 or 3. Applies to both engines.
- CLKS_PER_HALF_BIT, 2: master i_Clk cycles per SCLK half-period; legal range ≥ 2.

Ports:
- i_Clk in 1: system clock; all logic runs on its rising edge.
- i_Rst_L in 1: reset, synchronous, active-low.
- i_M_TX_Byte in 8: master byte to send; sampled with i_M_TX_DV.
- i_M_TX_DV in 1: master start pulse; honoured only while o_M_TX_Ready = 1.
- o_M_TX_Ready out 1: master idle, ready to accept a byte.
- o_M_RX_DV out 1: one-cycle pulse; o_M_RX_Byte valid.
- o_M_RX_Byte out 8: byte shifted in on MISO.
- o_M_SPI_Clk out 1: SCLK; idles at CPOL.
- i_M_SPI_MISO in 1: master serial input.
- o_M_SPI_MOSI out 1: master serial output, MSB first.
- i_S_TX_DV in 1: slave load pulse for i_S_TX_Byte.
- i_S_TX_Byte in 8: slave byte for the next transfer.
- o_S_RX_DV out 1: one-cycle pulse; o_S_RX_Byte valid.
- o_S_RX_Byte out 8: byte received on MOSI.
- i_S_SPI_Clk in 1: SCLK seen by slave (synchronous to i_Clk).
- i_S_SPI_MOSI in 1: slave serial input.
- o_S_SPI_MISO out 1: slave serial output; high-Z while CS_n = 1.
- i_S_SPI_CS_n in 1: slave chip select, active-low.

## Operation
- Master: chip select is driven by the caller, not the block.
- Master FSM: IDLE (Ready=1, SCLK=CPOL) → on i_M_TX_DV latch byte, Ready=0 → XFER: emit 16 SCLK edges, one every CLKS_PER_HALF_BIT cycles → DONE: o_M_RX_DV pulse, Ready=1 same cycle → IDLE.
- Master data: CPHA=0 puts MSB on MOSI in the DV cycle, shifts on trailing edges, samples MISO on leading edges; CPHA=1 shifts on leading edges (first leading edge drives MSB), samples on trailing edges.
- Back-to-back bytes: new DV is accepted once Ready returns; SCLK stays at CPOL between bytes.
- Slave: registers i_S_SPI_Clk once, detects leading/trailing edges against the previous sample. Samples MOSI on the sampling edge (CPHA=0 leading, CPHA=1 trailing), MSB first; 3-bit counter.
- After the 8th sample, o_S_RX_Byte updates and o_S_RX_DV pulses for exactly one i_Clk cycle.
- CS_n high resets the bit counter and discards a partial byte (no RX_DV).
- Slave TX: i_S_TX_DV loads i_S_TX_Byte into a holding register, which is copied into the shift register at each byte boundary (CS_n fall or bit-counter wrap). With no new load the holding value repeats. CPHA=0: MSB is on MISO as soon as CS_n is low. Otherwise, bits shift out on the non-sampling edge.
- Loopback (RX_DV→TX_DV, RX_Byte→TX_Byte): the slave echoes byte N during byte N+1.
- i_S_TX_DV and the receive completion in the same cycle: the load wins for the holding register. Shift contents are unaffected until the next boundary.

## Timing
- Reset values: o_M_TX_Ready=1, o_M_RX_DV=0, o_M_RX_Byte=0, o_M_SPI_Clk=CPOL, o_M_SPI_MOSI=0, o_S_RX_DV=0, o_S_RX_Byte=0. Slave holding register = 0x00. o_S_SPI_MISO=Z.
- Reset mid-transfer aborts both engines immediately. SCLK returns to CPOL.
- Master latency: DV cycle to o_M_RX_DV = 16·CLKS_PER_HALF_BIT + 2 cycles (±1 allowed, fixed per implementation). Ready is low the whole time.
- Slave: MISO update within 2 i_Clk cycles of the SCLK shift edge. This guarantees setup for a master sampling CLKS_PER_HALF_BIT ≥ 2 cycles later.
- o_S_RX_DV fires 1–2 cycles after the 8th sampling edge.

## Test plan
- Reset, mode 1, CLKS_PER_HALF_BIT=2 loopback; send 0xC1 with CS_n pulsed → o_S_RX_Byte=0xC1, one RX_DV pulse; master receives 0x00 (reset holding value).
- Multi-byte under one CS_n: 00,01,80,FF,55,AA → slave RX_DV ×6 with the same bytes; master RX sequence 0xC1(held),00,01,80,FF,55.
- All four SPI_MODEs send 0xA5 → SCLK idles at CPOL, exactly 16 edges, slave receives 0xA5.
- CS_n raised after 4 bits, then full byte 0x3C → no RX_DV for the partial byte, next byte received as 0x3C.
- Ready/DV handshake: DV asserted while busy is ignored; Ready low for the full transfer, then RX_DV and Ready high in the same cycle.
- Reset asserted mid-byte → all outputs return to reset values next cycle and MISO goes Z.
